dp_aux_sink_responder: RTL and testbench

- Sink-side (DPRX) AUX responder: the far end of the AUX channel driven by the source LPM/SPM policy makers.
- Receives decoded AUX request bytes from the sink PHY deserializer and decodes CMD/ADDR/LEN.
- Services native reads and writes against a local DPCD register array, then streams reply bytes (ACK/NACK/DEFER, data, M byte) back to the PHY serializer.
- I2C-over-AUX requests are not serviced.

---
 rtl/dp_aux_sink_responder.sv | 236 +++++++++++++++++++++++
 tb/tb_dp_aux_sink_responder.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/dp_aux_sink_responder.sv
// Sink-side AUX responder: native DPCD read/write service, DEFER/NACK/I2C_NACK replies (DP_AUX_DPCD_WRITE_PROTECT_EN makes addr < RO_LIMIT read-only).
// Latency: reply 2 cycles after request eop, +1 per committed write byte; tx stalls hold the current reply byte.
module dp_aux_sink_responder #(
  parameter  int DPCD_DEPTH = 256,
  parameter  int MAX_BURST  = 16,
  parameter  int RO_LIMIT   = 16,
  localparam int AW = $clog2(DPCD_DEPTH),
  localparam int BW = $clog2(MAX_BURST),
  localparam int CW = $clog2(MAX_BURST + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [7:0]    rx_data,
  input  logic          rx_vld,
  input  logic          rx_eop,
  input  logic          sink_busy,
  output logic [7:0]    tx_data,
  output logic          tx_vld,
  input  logic          tx_rdy,
  output logic          tx_eop,
  output logic          rx_drop,
  input  logic [AW-1:0] host_addr,
  output logic [7:0]    host_rdata
);

`ifdef DP_AUX_DPCD_WRITE_PROTECT_EN
  localparam bit WP_EN = 1'b1;
`else
  localparam bit WP_EN = 1'b0;
`endif

  localparam logic [3:0] C_ACK = 4'b0000, C_NACK = 4'b0001, C_DEFER = 4'b0010, C_I2C_NACK = 4'b0100;

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_WDATA, S_CHECK, S_COMMIT, S_REPLY} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cmd_q, cmd_d;
  logic [19:0]   addr_q, addr_d;
  logic [7:0]    len_q, len_d;
  logic [1:0]    hdr_cnt_q, hdr_cnt_d;
  logic [CW-1:0] buf_cnt_q, buf_cnt_d;
  logic [CW-1:0] wr_idx_q, wr_idx_d;
  logic [3:0]    code_q, code_d;
  logic          rd_reply_q, rd_reply_d;
  logic [7:0]    rep_len_q, rep_len_d;
  logic [7:0]    rep_idx_q, rep_idx_d;
  logic [7:0]    m_q, m_d;
  logic          rx_drop_q, rx_drop_d;
  logic [7:0]    buf_q  [MAX_BURST];
  logic [7:0]    dpcd_q [DPCD_DEPTH];

  logic          buf_we, dpcd_we;
  logic          is_wr, is_rd;
  logic [8:0]    xfer_len;
  logic [19:0]   wr_addr, nxt_addr, rd_addr;
  logic [7:0]    rep_byte;

  function automatic logic writable(input logic [19:0] a);
    return (a < 20'(DPCD_DEPTH)) && !(WP_EN && (a < 20'(RO_LIMIT)));
  endfunction

  assign is_wr    = (cmd_q == 4'b1000);
  assign is_rd    = (cmd_q == 4'b1001);
  assign xfer_len = {1'b0, len_q} + 9'd1;
  assign wr_addr  = addr_q + 20'(wr_idx_q);
  assign nxt_addr = wr_addr + 20'd1;
  assign rd_addr  = addr_q + 20'(rep_idx_q) - 20'd1;

  // Reply byte 0 is the code; read replies then stream DPCD, NACK-on-write sends M.
  always_comb begin
    rep_byte = 8'h00;
    if (rep_idx_q == 8'd0)   rep_byte = {code_q, 4'b0000};
    else if (rd_reply_q)     rep_byte = (rd_addr < 20'(DPCD_DEPTH)) ? dpcd_q[rd_addr[AW-1:0]] : 8'h00;
    else                     rep_byte = m_q;
  end

  assign tx_vld     = (state_q == S_REPLY);
  assign tx_data    = tx_vld ? rep_byte : 8'h00;
  assign tx_eop     = tx_vld && (rep_idx_q == rep_len_q - 8'd1);
  assign rx_drop    = rx_drop_q;
  assign host_rdata = dpcd_q[host_addr];

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    len_d      = len_q;
    hdr_cnt_d  = hdr_cnt_q;
    buf_cnt_d  = buf_cnt_q;
    wr_idx_d   = wr_idx_q;
    code_d     = code_q;
    rd_reply_d = rd_reply_q;
    rep_len_d  = rep_len_q;
    rep_idx_d  = rep_idx_q;
    m_d        = m_q;
    rx_drop_d  = 1'b0;
    buf_we     = 1'b0;
    dpcd_we    = 1'b0;
    case (state_q)
      S_IDLE: begin
        buf_cnt_d = '0;
        if (rx_vld) begin
          cmd_d     = rx_data[7:4];
          addr_d    = {rx_data[3:0], 16'h0000};
          hdr_cnt_d = 2'd1;
          if (rx_eop) rx_drop_d = 1'b1;
          else        state_d   = S_HDR;
        end
      end
      S_HDR: begin
        if (rx_vld) begin
          hdr_cnt_d = hdr_cnt_q + 2'd1;
          case (hdr_cnt_q)
            2'd1:    addr_d[15:8] = rx_data;
            2'd2:    addr_d[7:0]  = rx_data;
            default: len_d        = rx_data;
          endcase
          // A write whose header ends the request carries no data and is malformed.
          if (rx_eop && (hdr_cnt_q != 2'd3 || is_wr)) begin
            rx_drop_d = 1'b1;
            state_d   = S_IDLE;
          end else if (hdr_cnt_q == 2'd3) begin
            state_d = rx_eop ? S_CHECK : S_WDATA;
          end
        end
      end
      S_WDATA: begin
        if (rx_vld) begin
          if (buf_cnt_q == CW'(MAX_BURST)) begin
            rx_drop_d = 1'b1;
            state_d   = S_IDLE;
          end else begin
            buf_we    = 1'b1;
            buf_cnt_d = buf_cnt_q + 1'b1;
            if (rx_eop) begin
              if (is_rd || (is_wr && (9'(buf_cnt_q) + 9'd1 != xfer_len))) begin
                rx_drop_d = 1'b1;
                state_d   = S_IDLE;
              end else begin
                state_d = S_CHECK;
              end
            end
          end
        end
      end
      S_CHECK: begin
        rx_drop_d  = rx_vld;
        state_d    = S_REPLY;
        rep_idx_d  = 8'd0;
        rd_reply_d = 1'b0;
        rep_len_d  = 8'd1;
        m_d        = 8'd0;
        if (sink_busy) begin
          code_d = C_DEFER;
        end else if (!cmd_q[3]) begin
          code_d = C_I2C_NACK;
        end else if (!(is_wr || is_rd) || (xfer_len > 9'(MAX_BURST))) begin
          code_d = C_NACK;
          if (is_wr) rep_len_d = 8'd2;
        end else if (is_rd) begin
          code_d     = C_ACK;
          rd_reply_d = 1'b1;
          rep_len_d  = len_q + 8'd2;
        end else if (writable(addr_q)) begin
          state_d  = S_COMMIT;
          wr_idx_d = '0;
        end else begin
          code_d    = C_NACK;
          rep_len_d = 8'd2;
        end
      end
      S_COMMIT: begin
        // Look one address ahead so the stop costs no extra cycle.
        rx_drop_d = rx_vld;
        dpcd_we   = 1'b1;
        if (9'(wr_idx_q) + 9'd1 == xfer_len) begin
          state_d   = S_REPLY;
          code_d    = C_ACK;
          rep_len_d = 8'd1;
        end else if (!writable(nxt_addr)) begin
          state_d   = S_REPLY;
          code_d    = C_NACK;
          rep_len_d = 8'd2;
          m_d       = 8'(wr_idx_q) + 8'd1;
        end else begin
          wr_idx_d = wr_idx_q + 1'b1;
        end
      end
      S_REPLY: begin
        rx_drop_d = rx_vld;
        if (tx_rdy) begin
          if (tx_eop) state_d   = S_IDLE;
          else        rep_idx_d = rep_idx_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cmd_q      <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      hdr_cnt_q  <= '0;
      buf_cnt_q  <= '0;
      wr_idx_q   <= '0;
      code_q     <= '0;
      rd_reply_q <= 1'b0;
      rep_len_q  <= '0;
      rep_idx_q  <= '0;
      m_q        <= '0;
      rx_drop_q  <= 1'b0;
      for (int i = 0; i < MAX_BURST; i++)  buf_q[i]  <= '0;
      for (int i = 0; i < DPCD_DEPTH; i++) dpcd_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      hdr_cnt_q  <= hdr_cnt_d;
      buf_cnt_q  <= buf_cnt_d;
      wr_idx_q   <= wr_idx_d;
      code_q     <= code_d;
      rd_reply_q <= rd_reply_d;
      rep_len_q  <= rep_len_d;
      rep_idx_q  <= rep_idx_d;
      m_q        <= m_d;
      rx_drop_q  <= rx_drop_d;
      if (buf_we)  buf_q[buf_cnt_q[BW-1:0]] <= rx_data;
      if (dpcd_we) dpcd_q[wr_addr[AW-1:0]]  <= buf_q[wr_idx_q[BW-1:0]];
    end
  end

endmodule

// File: tb/tb_dp_aux_sink_responder.sv
// Directed bench for dp_aux_sink_responder: hand-computed replies, latencies and DPCD contents.
module tb_dp_aux_sink_responder;
  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] rx_data;
  logic       rx_vld, rx_eop, sink_busy;
  logic [7:0] tx_data;
  logic       tx_vld, tx_rdy, tx_eop, rx_drop;
  logic [7:0] host_addr, host_rdata;

  int         n_assert = 0;
  int         n_fail   = 0;
  logic [7:0] rep [32];
  logic       rep_eop [32];
  int         rep_n, lat;

  always #5 clk = ~clk;

  dp_aux_sink_responder dut (
    .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_vld(rx_vld), .rx_eop(rx_eop),
    .sink_busy(sink_busy), .tx_data(tx_data), .tx_vld(tx_vld), .tx_rdy(tx_rdy), .tx_eop(tx_eop),
    .rx_drop(rx_drop), .host_addr(host_addr), .host_rdata(host_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic eop);
    rx_data = b; rx_vld = 1'b1; rx_eop = eop;
    tick();
    rx_vld = 1'b0; rx_eop = 1'b0; rx_data = 8'h00;
  endtask

  // Called the cycle after the eop byte was taken; lat counts cycles from the eop cycle.
  task automatic get_reply;
    logic last;
    lat = 1; rep_n = 0;
    while (!tx_vld && lat < 40) begin tick(); lat++; end
    while (tx_vld && rep_n < 32) begin
      last = tx_eop;
      rep[rep_n] = tx_data; rep_eop[rep_n] = tx_eop; rep_n++;
      tick();
      if (last) break;
    end
  endtask

  task automatic check_reply(input string tag, input int exp_n, input logic [23:0] exp);
    int eop_at;
    eop_at = -1;
    check({tag, "_len"}, rep_n, exp_n);
    for (int i = 0; i < rep_n && i < 3; i++) check($sformatf("%s_b%0d", tag, i), rep[i], exp[23-8*i -: 8]);
    for (int i = 0; i < rep_n; i++) if (rep_eop[i] && eop_at < 0) eop_at = i;
    check({tag, "_eop"}, eop_at, rep_n - 1);
  endtask

  task automatic check_host(input string tag, input logic [7:0] a, input logic [7:0] exp);
    host_addr = a;
    #1;
    check(tag, host_rdata, exp);
  endtask

  initial begin
    int saw_vld;
    reset_n = 1'b0; rx_data = 8'h00; rx_vld = 1'b0; rx_eop = 1'b0;
    sink_busy = 1'b0; tx_rdy = 1'b1; host_addr = 8'h00;
    #2;
    check("rst_tx_vld", tx_vld, 1'b0);
    check("rst_tx_eop", tx_eop, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_rx_drop", rx_drop, 1'b0);
    check_host("rst_dpcd10", 8'h10, 8'h00);
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // Native write of two bytes at 0x010
    send(8'h80, 0); send(8'h00, 0); send(8'h10, 0); send(8'h01, 0); send(8'hAA, 0); send(8'hBB, 1);
    get_reply();
    check_reply("wr", 1, 24'h00_0000);
    check("wr_lat", lat, 4);
    check_host("wr_dpcd10", 8'h10, 8'hAA);
    check_host("wr_dpcd11", 8'h11, 8'hBB);

    // Native read back
    send(8'h90, 0); send(8'h00, 0); send(8'h10, 0); send(8'h01, 1);
    get_reply();
    check_reply("rd", 3, 24'h00_AA_BB);
    check("rd_lat", lat, 2);

    // Write running off the end of the array
    send(8'h80, 0); send(8'h00, 0); send(8'hFE, 0); send(8'h03, 0);
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 1);
    get_reply();
    check_reply("wr_oor", 2, 24'h10_02_00);
    check("wr_oor_lat", lat, 4);
    check_host("wr_oor_fe", 8'hFE, 8'h11);
    check_host("wr_oor_ff", 8'hFF, 8'h22);
    check_host("wr_oor_00", 8'h00, 8'h00);

    // Busy sink defers; I2C-over-AUX is NACKed
    sink_busy = 1'b1;
    send(8'h90, 0); send(8'h00, 0); send(8'h10, 0); send(8'h01, 1);
    get_reply();
    sink_busy = 1'b0;
    check_reply("defer", 1, 24'h20_0000);
    check("defer_lat", lat, 2);
    check_host("defer_dpcd10", 8'h10, 8'hAA);
    send(8'h40, 0); send(8'h00, 0); send(8'h50, 0); send(8'h00, 1);
    get_reply();
    check_reply("i2c", 1, 24'h40_0000);

    // Malformed: write short of LEN+1 data bytes
    send(8'h80, 0); send(8'h00, 0); send(8'h20, 0); send(8'h01, 0); send(8'h33, 1);
    check("short_drop", rx_drop, 1'b1);
    saw_vld = 0;
    for (int i = 0; i < 8; i++) begin
      if (tx_vld) saw_vld++;
      tick();
    end
    check("short_no_reply", saw_vld, 0);
    check("short_drop_clr", rx_drop, 1'b0);
    check_host("short_dpcd20", 8'h20, 8'h00);

    // Malformed: eop inside the header
    send(8'h90, 0); send(8'h00, 1);
    check("hdr_eop_drop", rx_drop, 1'b1);
    tick();

    // Stalled reply holds data; a stray rx byte is dropped without disturbing it
    tx_rdy = 1'b0;
    send(8'h90, 0); send(8'h00, 0); send(8'h10, 0); send(8'h01, 1);
    for (int i = 0; i < 40 && !tx_vld; i++) tick();
    check("stall_b0", tx_data, 8'h00);
    tx_rdy = 1'b1;
    tick();
    tx_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stall_hold%0d", i), {tx_vld, tx_data}, {1'b1, 8'hAA});
      if (i == 1) begin
        send(8'h55, 0);
        check("stall_rx_drop", rx_drop, 1'b1);
      end else begin
        tick();
      end
    end
    tx_rdy = 1'b1;
    get_reply();
    check_reply("stall_rest", 2, 24'hAA_BB_00);

    // Async reset in the middle of a reply
    tx_rdy = 1'b0;
    send(8'h90, 0); send(8'h00, 0); send(8'h10, 0); send(8'h01, 1);
    for (int i = 0; i < 40 && !tx_vld; i++) tick();
    check("pre_rst_vld", tx_vld, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_vld", tx_vld, 1'b0);
    check("async_rst_data", tx_data, 8'h00);
    tick(); tick();
    reset_n = 1'b1;
    tx_rdy = 1'b1;
    tick();
    send(8'h90, 0); send(8'h00, 0); send(8'h10, 0); send(8'h01, 1);
    get_reply();
    check_reply("post_rst_rd", 3, 24'h00_00_00);

    // Write into the low (optionally protected) region
    send(8'h80, 0); send(8'h00, 0); send(8'h05, 0); send(8'h00, 0); send(8'h77, 1);
    get_reply();
`ifdef DP_AUX_DPCD_WRITE_PROTECT_EN
    check_reply("wp", 2, 24'h10_00_00);
    check("wp_lat", lat, 2);
    check_host("wp_dpcd05", 8'h05, 8'h00);
`else
    check_reply("wp", 1, 24'h00_0000);
    check("wp_lat", lat, 3);
    check_host("wp_dpcd05", 8'h05, 8'h77);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
